instr_encoder: RTL and testbench

Pipelined RV64 instruction encoder: the inverse of the instruction decoder. It accepts a decoded operation (op select, register indices, 32-bit immediate) over a valid/ready handshake and emits 32-bit machine words over a second valid/ready handshake. The `LI` pseudo-instruction is expanded to a two-word `lui`+`addi` sequence when needed. It sits between the test-program generator or patch logic and the instruction memory writer, so it also drives decoder self-checks.

---
 rtl/instr_encoder_if.sv | 27 ++
 rtl/instr_encoder.sv | 225 ++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: decoded-operation request channel
// and encoded-word response channel, each a valid/ready handshake.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    // Producer of requests / consumer of encoded words.
    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    // The encoder itself.
    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/instr_encoder.sv
// RV64 instruction encoder: decoded op -> 32-bit machine word, with optional
// two-word LI expansion (lui+addi) enabled by INSTR_ENCODER_LI_EXPAND_EN.
module instr_encoder (
    input  logic           clk,
    input  logic           reset_n,
    instr_encoder_if.slave bus
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_XOR   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_ADDI  = 4'd5;
    localparam logic [3:0] OP_XORI  = 4'd6;
    localparam logic [3:0] OP_ORI   = 4'd7;
    localparam logic [3:0] OP_ANDI  = 4'd8;
    localparam logic [3:0] OP_LUI   = 4'd9;
    localparam logic [3:0] OP_AUIPC = 4'd10;
    localparam logic [3:0] OP_JAL   = 4'd11;
    localparam logic [3:0] OP_BEQ   = 4'd12;
    localparam logic [3:0] OP_LD    = 4'd13;
    localparam logic [3:0] OP_SD    = 4'd14;
    localparam logic [3:0] OP_LI    = 4'd15;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ONE  = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction

    logic [1:0]  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;
`ifdef INSTR_ENCODER_LI_EXPAND_EN
    logic [31:0] pend_q, pend_d;
    logic [31:0] second_word;
    logic        two_word;
    logic [31:0] li_hi;
`endif

    logic [31:0] imm;
    logic        fit12, fit13, fit21;
    logic [2:0]  alu_f3;
    logic [31:0] first_word;
    logic        first_err;
    logic        accept;

    assign imm   = bus.in_imm;
    assign fit12 = (imm[31:11] == {21{imm[11]}});
    assign fit13 = (imm[31:12] == {20{imm[12]}});
    assign fit21 = (imm[31:20] == {12{imm[20]}});
`ifdef INSTR_ENCODER_LI_EXPAND_EN
    // Rounding constant compensates for addi sign-extending the low 12 bits.
    assign li_hi = imm + 32'h0000_0800;
`endif

    always_comb begin
        case (bus.in_op)
            OP_XOR, OP_XORI: alu_f3 = 3'b100;
            OP_OR,  OP_ORI:  alu_f3 = 3'b110;
            OP_AND, OP_ANDI: alu_f3 = 3'b111;
            default:         alu_f3 = 3'b000;
        endcase
    end

    always_comb begin
        first_word = '0;
        first_err  = 1'b0;
`ifdef INSTR_ENCODER_LI_EXPAND_EN
        second_word = '0;
        two_word    = 1'b0;
`endif
        case (bus.in_op)
            OP_ADD, OP_XOR, OP_OR, OP_AND:
                first_word = enc_r(7'b0000000, bus.in_rs2, bus.in_rs1, alu_f3, bus.in_rd, OPC_OP);
            OP_SUB:
                first_word = enc_r(7'b0100000, bus.in_rs2, bus.in_rs1, alu_f3, bus.in_rd, OPC_OP);
            OP_ADDI, OP_XORI, OP_ORI, OP_ANDI: begin
                first_word = enc_i(imm[11:0], bus.in_rs1, alu_f3, bus.in_rd, OPC_OPIMM);
                first_err  = !fit12;
            end
            OP_LUI:
                first_word = enc_u(imm[31:12], bus.in_rd, OPC_LUI);
            OP_AUIPC:
                first_word = enc_u(imm[31:12], bus.in_rd, OPC_AUIPC);
            OP_JAL: begin
                first_word = enc_j(imm[20:0], bus.in_rd);
                first_err  = !fit21 || imm[0];
            end
            OP_BEQ: begin
                first_word = enc_b(imm[12:0], bus.in_rs2, bus.in_rs1, 3'b000);
                first_err  = !fit13 || imm[0];
            end
            OP_LD: begin
                first_word = enc_i(imm[11:0], bus.in_rs1, 3'b011, bus.in_rd, OPC_LOAD);
                first_err  = !fit12;
            end
            OP_SD: begin
                first_word = enc_s(imm[11:0], bus.in_rs2, bus.in_rs1, 3'b011);
                first_err  = !fit12;
            end
            OP_LI: begin
`ifdef INSTR_ENCODER_LI_EXPAND_EN
                if (fit12) begin
                    first_word = enc_i(imm[11:0], 5'd0, 3'b000, bus.in_rd, OPC_OPIMM);
                end else begin
                    two_word    = 1'b1;
                    first_word  = enc_u(li_hi[31:12], bus.in_rd, OPC_LUI);
                    second_word = enc_i(imm[11:0], bus.in_rd, 3'b000, bus.in_rd, OPC_OPIMM);
                end
`else
                first_word = enc_i(imm[11:0], 5'd0, 3'b000, bus.in_rd, OPC_OPIMM);
                first_err  = !fit12;
`endif
            end
            default: begin
                first_word = '0;
                first_err  = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_ONE) && bus.out_ready);
    assign bus.out_valid = (state_q != ST_IDLE);
    assign bus.out_instr = instr_q;
    assign bus.out_err   = err_q;
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        err_d   = err_q;
`ifdef INSTR_ENCODER_LI_EXPAND_EN
        pend_d  = pend_q;
`endif
        case (state_q)
            ST_IDLE, ST_ONE: begin
                // In ONE, accept implies out_ready, so the new word replaces
                // the old one at the same edge the old one is handed off.
                if (accept) begin
                    instr_d = first_word;
                    err_d   = first_err;
`ifdef INSTR_ENCODER_LI_EXPAND_EN
                    pend_d  = second_word;
                    state_d = two_word ? ST_HI : ST_ONE;
`else
                    state_d = ST_ONE;
`endif
                end else if ((state_q == ST_ONE) && bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HI: begin
`ifdef INSTR_ENCODER_LI_EXPAND_EN
                if (bus.out_ready) begin
                    instr_d = pend_q;
                    err_d   = 1'b0;
                    state_d = ST_ONE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            err_q   <= 1'b0;
`ifdef INSTR_ENCODER_LI_EXPAND_EN
            pend_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            err_q   <= err_d;
`ifdef INSTR_ENCODER_LI_EXPAND_EN
            pend_q  <= pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: expected words are queued on accept and
// checked in order as the output handshake completes.
module tb_instr_encoder;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    instr_encoder_if bus ();

    instr_encoder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad = 0;
    int cycles = 0;

    logic [32:0] sb[$];
    logic [31:0] exp_w0, exp_w1;
    logic        exp_e0, exp_two;
    logic        acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        logic [32:0] item;
        @(negedge clk);
        if (bus.out_valid && bus.out_ready) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_word observed=%h expected=none", bus.out_instr);
            end
            if (sb.size() != 0) begin
                item = sb.pop_front();
                $display("word %h err %0d", bus.out_instr, bus.out_err);
                chk("word", bus.out_instr, item[31:0]);
                chk("err", {31'd0, bus.out_err}, {31'd0, item[32]});
            end
        end
        acc = bus.in_valid && bus.in_ready;
        if (acc) begin
            sb.push_back({exp_e0, exp_w0});
            if (exp_two) sb.push_back({1'b0, exp_w1});
        end
        @(posedge clk);
        #1;
        cycles++;
    endtask

    task automatic present(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm,
                           input logic [31:0] w0, input logic e0,
                           input logic two, input logic [31:0] w1);
        bus.in_op  = op;
        bus.in_rd  = rd;
        bus.in_rs1 = rs1;
        bus.in_rs2 = rs2;
        bus.in_imm = imm;
        bus.in_valid = 1'b1;
        exp_w0 = w0;
        exp_e0 = e0;
        exp_two = two;
        exp_w1 = w1;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] w0, input logic e0,
                        input logic two, input logic [31:0] w1);
        int n;
        present(op, rd, rs1, rs2, imm, w0, e0, two, w1);
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            tick();
            n++;
        end
        total++;
        assert (acc) else begin
            bad++;
            $error("FAIL accept_timeout observed=%0d expected=1", acc);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        bus.out_ready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_left", sb.size(), 32'd0);
    endtask

    initial begin
        int c0;
        bus.in_valid = 1'b0;
        bus.in_op = '0;
        bus.in_rd = '0;
        bus.in_rs1 = '0;
        bus.in_rs2 = '0;
        bus.in_imm = '0;
        bus.out_ready = 1'b1;
        exp_w0 = '0; exp_w1 = '0; exp_e0 = 1'b0; exp_two = 1'b0; acc = 1'b0;

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_instr", bus.out_instr, 32'd0);
        chk("rst_out_err", {31'd0, bus.out_err}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Basic ALU, back-to-back at full rate
        c0 = cycles;
        send(4'd5, 5'd1, 5'd2, 5'd0, 32'd5, 32'h00510093, 1'b0, 1'b0, 32'd0);
        chk("lat_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("lat_instr", bus.out_instr, 32'h00510093);
        send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0, 1'b0, 32'd0);
        send(4'd1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1'b0, 1'b0, 32'd0);
        chk("full_rate_cycles", cycles - c0, 32'd3);
        send(4'd4, 5'd6, 5'd7, 5'd8, 32'd0, 32'h0083F333, 1'b0, 1'b0, 32'd0);
        send(4'd6, 5'd4, 5'd4, 5'd0, 32'hFFFFFFFF, 32'hFFF24213, 1'b0, 1'b0, 32'd0);
        send(4'd13, 5'd3, 5'd1, 5'd0, 32'd16, 32'h0100B183, 1'b0, 1'b0, 32'd0);
        send(4'd14, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020B423, 1'b0, 1'b0, 32'd0);
        send(4'd9, 5'd7, 5'd0, 5'd0, 32'hABCDE123, 32'hABCDE3B7, 1'b0, 1'b0, 32'd0);
        send(4'd10, 5'd1, 5'd0, 5'd0, 32'h00001000, 32'h00001097, 1'b0, 1'b0, 32'd0);
        send(4'd12, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0, 1'b0, 32'd0);
        drain();

        // Range errors
        send(4'd12, 5'd0, 5'd1, 5'd2, 32'd3, 32'h00208163, 1'b1, 1'b0, 32'd0);
        send(4'd5, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h80000093, 1'b1, 1'b0, 32'd0);
        send(4'd11, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h001000EF, 1'b0, 1'b0, 32'd0);
        drain();

        // LI
`ifdef INSTR_ENCODER_LI_EXPAND_EN
        send(4'd15, 5'd5, 5'd0, 5'd0, 32'h12345678, 32'h123452B7, 1'b0, 1'b1, 32'h67828293);
        chk("li_in_ready_hi", {31'd0, bus.in_ready}, 32'd0);
        send(4'd15, 5'd5, 5'd0, 5'd0, 32'h00000FFF, 32'h000012B7, 1'b0, 1'b1, 32'hFFF28293);
`else
        send(4'd15, 5'd5, 5'd0, 5'd0, 32'h12345678, 32'h67800293, 1'b1, 1'b0, 32'd0);
        chk("li_in_ready_one", {31'd0, bus.in_ready}, 32'd1);
        send(4'd15, 5'd5, 5'd0, 5'd0, 32'h00000FFF, 32'hFFF00293, 1'b1, 1'b0, 32'd0);
`endif
        send(4'd15, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00293, 1'b0, 1'b0, 32'd0);
        drain();

        // Backpressure: stalled output holds its word and blocks new requests
        bus.out_ready = 1'b0;
        send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0, 1'b0, 32'd0);
        present(4'd1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp_hold_instr", bus.out_instr, 32'h002081B3);
        end
        chk("bp_no_accept", sb.size(), 32'd1);
        bus.out_ready = 1'b1;
        begin
            int n;
            acc = 1'b0;
            n = 0;
            while (!acc && n < 50) begin
                tick();
                n++;
            end
            chk("bp_accept", {31'd0, acc}, 32'd1);
        end
        bus.in_valid = 1'b0;
        drain();

        // Reset while the lui is held; the pending addi must be discarded
        bus.out_ready = 1'b0;
`ifdef INSTR_ENCODER_LI_EXPAND_EN
        send(4'd15, 5'd5, 5'd0, 5'd0, 32'h12345678, 32'h123452B7, 1'b0, 1'b1, 32'h67828293);
`else
        send(4'd15, 5'd5, 5'd0, 5'd0, 32'h12345678, 32'h67800293, 1'b1, 1'b0, 32'd0);
`endif
        tick();
        chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("pre_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_instr", bus.out_instr, 32'd0);
        chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        sb.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
        bus.out_ready = 1'b1;
        send(4'd5, 5'd1, 5'd2, 5'd0, 32'd5, 32'h00510093, 1'b0, 1'b0, 32'd0);
        chk("post_rst_instr", bus.out_instr, 32'h00510093);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
